// File: rtl/exe_mem_req_stage_if.sv
// SRAM-like data bus between the execute-stage request front end and memory.
// Request side is driven by the stage (master); the handshake returns come from memory (slave).
interface exe_mem_req_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  localparam int unsigned BW = DW / 8;

  logic          data_req;
  logic          data_wr;
  logic [BW-1:0] data_be;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;

  modport master (
    output data_req, data_wr, data_be, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_be, data_addr, data_wdata,
    output data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/exe_mem_req_stage.sv
// Execute-stage load/store front end: holds one decoded op, forms address/lanes/data,
// issues a bus request with an outstanding-request limit, misalign trap and flush.
module exe_mem_req_stage #(
  parameter  int unsigned DW      = 32,
  parameter  int unsigned AW      = 32,
  parameter  int unsigned MAX_OUT = 2,
  parameter  int unsigned TAG_W   = 8,
  localparam int unsigned BW      = DW / 8,
  localparam int unsigned LB      = $clog2(BW)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             ds_to_es_valid,
  output logic             es_allowin,
  input  logic             ds_load,
  input  logic             ds_store,
  input  logic [1:0]       ds_size,
  input  logic             ds_sign_ext,
  input  logic [AW-1:0]    ds_base,
  input  logic [AW-1:0]    ds_offset,
  input  logic [DW-1:0]    ds_wdata,
  input  logic [TAG_W-1:0] ds_tag,
  input  logic             ms_allowin,
  output logic             es_to_ms_valid,
  output logic [TAG_W-1:0] es_to_ms_tag,
  output logic             es_to_ms_load,
  output logic             es_to_ms_sign,
  output logic [1:0]       es_to_ms_size,
  output logic [LB-1:0]    es_to_ms_lane,
  output logic             es_to_ms_excp,
  exe_mem_req_stage_if.master bus,
  output logic [2:0]       es_outstanding
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, state_nx;

  logic             es_valid;
  logic             op_load, op_store, op_sign;
  logic [1:0]       op_size;
  logic [AW-1:0]    op_base, op_off;
  logic [DW-1:0]    op_wdata;
  logic [TAG_W-1:0] op_tag;
  logic [2:0]       count;

  logic [AW-1:0] addr;
  logic          mem_op, size_bad, misalign, legal_mem, excp;
  logic          slot_free, req, ready_go, handoff, load_op;
  logic [BW-1:0] be_mask, be_lane;
  logic [DW-1:0] wdata_rep;
  int unsigned   nbytes;

  assign addr      = op_base + op_off;
  assign mem_op    = op_load | op_store;
  assign size_bad  = {1'b0, op_size} > 3'(LB);

  always_comb begin
    misalign = 1'b0;
    case (op_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = addr[0];
      2'd2:    misalign = |addr[1:0];
      default: misalign = |addr[2:0];
    endcase
  end

  assign legal_mem = es_valid & mem_op & ~(size_bad | misalign);
  assign excp      = es_valid & mem_op & (size_bad | misalign);
  assign slot_free = count < 3'(MAX_OUT);

  // Request is held only while waiting for acceptance; flush does not withdraw it in
  // the flush cycle itself, so an acceptance coinciding with flush is still counted.
  assign req      = legal_mem & slot_free & ((state == IDLE) | (state == REQ));
  assign ready_go = ~legal_mem | (state == DONE) | (req & bus.data_addr_ok);

  assign es_allowin     = ~es_valid | (ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid & ready_go & ~flush;
  assign handoff        = es_to_ms_valid & ms_allowin;
  assign load_op        = es_allowin & ds_to_es_valid & ~flush;

  always_comb begin
    nbytes    = 32'd1 << op_size;
    be_mask   = '0;
    wdata_rep = '0;
    for (int unsigned i = 0; i < BW; i++) begin
      be_mask[i]            = (i < nbytes);
      wdata_rep[8*i +: 8]   = op_wdata[8*(i & (nbytes - 1)) +: 8];
    end
    be_lane = be_mask << addr[LB-1:0];
  end

  assign bus.data_req   = req;
  assign bus.data_wr    = req & op_store;
  assign bus.data_be    = req ? be_lane : '0;
  assign bus.data_addr  = addr;
  assign bus.data_wdata = wdata_rep;

  assign es_to_ms_tag   = op_tag;
  assign es_to_ms_load  = op_load;
  assign es_to_ms_sign  = op_sign;
  assign es_to_ms_size  = op_size;
  assign es_to_ms_lane  = addr[LB-1:0];
  assign es_to_ms_excp  = excp;
  assign es_outstanding = count;

  // After a hand-off IDLE re-requests combinationally for the newly loaded op,
  // which covers the direct DONE->REQ path.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE, REQ: if (req) state_nx = bus.data_addr_ok ? (handoff ? IDLE : DONE) : REQ;
        DONE:      if (handoff) state_nx = IDLE;
        default:   state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid <= 1'b0;
    end else if (flush) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_load  <= 1'b0;
      op_store <= 1'b0;
      op_sign  <= 1'b0;
      op_size  <= '0;
      op_base  <= '0;
      op_off   <= '0;
      op_wdata <= '0;
      op_tag   <= '0;
    end else if (load_op) begin
      op_load  <= ds_load;
      op_store <= ds_store;
      op_sign  <= ds_sign_ext;
      op_size  <= ds_size;
      op_base  <= ds_base;
      op_off   <= ds_offset;
      op_wdata <= ds_wdata;
      op_tag   <= ds_tag;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if ((req & bus.data_addr_ok) & ~bus.data_data_ok) begin
      count <= count + 3'd1;
    end else if (~(req & bus.data_addr_ok) & bus.data_data_ok & (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

endmodule
